// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: requester ownership,
// arbitration FSM states and memory read/write direction constants.
package dmem_pkg;

  typedef enum logic {
    OWN_PIPE = 1'b0,
    OWN_DMA  = 1'b1
  } owner_e;

  typedef enum logic {
    PIPE_PRIO = 1'b0,
    DMA_PRIO  = 1'b1
  } arb_state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/dmem_rtag_pipe.sv
// Two-stage read-tag shift register. Each issued read pushes {valid, owner}
// so that the matching data beat two cycles later is steered to its owner.
module dmem_rtag_pipe
  import dmem_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   in_valid,
  input  owner_e in_owner,
  output logic   out_valid,
  output owner_e out_owner
);

  logic   s1_valid;
  owner_e s1_owner;

  // Shift tags one stage per cycle; reset drops all in-flight reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_owner  <= OWN_PIPE;
      out_valid <= 1'b0;
      out_owner <= OWN_PIPE;
    end else begin
      s1_valid  <= in_valid;
      s1_owner  <= in_owner;
      out_valid <= s1_valid;
      out_owner <= s1_owner;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the pipeline (normal priority)
// and a DMA/loader port. A starvation counter forces bounded DMA bursts.
//
// Handshake: a requester holds its request (pipe_en / dma_req) and its
// command fields stable until accepted. Acceptance is combinational in the
// same cycle: the pipeline is accepted when pipe_en=1 and pipe_stall=0, the
// DMA port when dma_gnt=1; the command is registered at that rising edge.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW           = 8,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = 8,
  parameter int MAX_BURST    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pipe_en,
  input  logic          pipe_rw,
  input  logic [AW-1:0] pipe_addr,
  input  logic [DW-1:0] pipe_wdata,
  output logic          pipe_stall,
  output logic [DW-1:0] pipe_rdata,
  output logic          pipe_rvalid,
  input  logic          dma_req,
  input  logic          dma_rw,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_rvalid,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output arb_state_e    dbg_state
);

  localparam int WCW = $clog2(STARVE_LIMIT + 1);
  localparam int BCW = $clog2(MAX_BURST + 1);

  arb_state_e     state, next_state;
  logic [WCW-1:0] wait_cnt, wait_nxt;
  logic [BCW-1:0] burst_cnt, burst_nxt;
  logic           pipe_granted, dma_granted;
  logic           rd_issue;
  owner_e         rd_owner;
  logic           tag_valid;
  owner_e         tag_owner;

  // Arbitration state and starvation/burst counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PIPE_PRIO;
      wait_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= next_state;
      wait_cnt  <= wait_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // Grant decision, next state and counter updates; nothing is granted in reset.
  always_comb begin
    next_state   = state;
    pipe_granted = 1'b0;
    dma_granted  = 1'b0;
    burst_nxt    = burst_cnt;
    wait_nxt     = wait_cnt;
    if (!reset) begin
      case (state)
        PIPE_PRIO: begin
          if (dma_req && (wait_cnt == WCW'(STARVE_LIMIT))) begin
            dma_granted = 1'b1;
            // A one-grant burst is already complete, so stay put.
            if (MAX_BURST > 1) begin
              next_state = DMA_PRIO;
              burst_nxt  = BCW'(1);
            end
          end else if (pipe_en) begin
            pipe_granted = 1'b1;
          end else if (dma_req) begin
            dma_granted = 1'b1;
          end
        end
        DMA_PRIO: begin
          if (dma_req) begin
            dma_granted = 1'b1;
            burst_nxt   = burst_cnt + BCW'(1);
            if (burst_cnt + BCW'(1) == BCW'(MAX_BURST)) begin
              next_state = PIPE_PRIO;
              burst_nxt  = '0;
            end
          end else begin
            // DMA went away: hand the slot straight back to the pipeline.
            next_state   = PIPE_PRIO;
            burst_nxt    = '0;
            pipe_granted = pipe_en;
          end
        end
        default: next_state = PIPE_PRIO;
      endcase
      if (!dma_req || dma_granted) begin
        wait_nxt = '0;
      end else if (wait_cnt != WCW'(STARVE_LIMIT)) begin
        wait_nxt = wait_cnt + WCW'(1);
      end
    end
  end

  assign pipe_stall = pipe_en & ~pipe_granted;
  assign dma_gnt    = dma_req & dma_granted;
  assign dbg_state  = state;

  // Register the winning command; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (pipe_granted) begin
      mem_en    <= 1'b1;
      mem_rw    <= pipe_rw;
      mem_addr  <= pipe_addr;
      mem_wdata <= pipe_wdata;
    end else if (dma_granted) begin
      mem_en    <= 1'b1;
      mem_rw    <= dma_rw;
      mem_addr  <= dma_addr;
      mem_wdata <= dma_wdata;
    end else begin
      mem_en <= 1'b0;
      mem_rw <= 1'b0;
    end
  end

  assign rd_issue = (pipe_granted && (pipe_rw == RW_READ)) ||
                    (dma_granted  && (dma_rw  == RW_READ));
  assign rd_owner = dma_granted ? OWN_DMA : OWN_PIPE;

  dmem_rtag_pipe u_rtag (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_issue),
    .in_owner  (rd_owner),
    .out_valid (tag_valid),
    .out_owner (tag_owner)
  );

  assign pipe_rdata  = mem_rdata;
  assign dma_rdata   = mem_rdata;
  assign pipe_rvalid = tag_valid && (tag_owner == OWN_PIPE);
  assign dma_rvalid  = tag_valid && (tag_owner == OWN_DMA);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenario tasks plus a randomized phase,
// with a negedge monitor comparing against a cycle-level reference model,
// a shadow memory and an expected read-data queue.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int AW           = 8;
  localparam int DW           = 8;
  localparam int STARVE_LIMIT = 8;
  localparam int MAX_BURST    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          pipe_en, pipe_rw;
  logic [AW-1:0] pipe_addr;
  logic [DW-1:0] pipe_wdata;
  logic          pipe_stall, pipe_rvalid;
  logic [DW-1:0] pipe_rdata;
  logic          dma_req, dma_rw;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt, dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic          mem_en, mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  arb_state_e    dbg_state;

  int errors = 0;
  int checks = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  dmem_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset(reset),
    .pipe_en(pipe_en), .pipe_rw(pipe_rw), .pipe_addr(pipe_addr),
    .pipe_wdata(pipe_wdata), .pipe_stall(pipe_stall),
    .pipe_rdata(pipe_rdata), .pipe_rvalid(pipe_rvalid),
    .dma_req(dma_req), .dma_rw(dma_rw), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
    .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- synchronous RAM model ----------------
  logic [DW-1:0] ram [256];
  logic [DW-1:0] ram_q;
  bit            ram_init = 1'b0;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= DW'((i * 7 + 3) & 8'hFF);
      ram_init <= 1'b1;
    end else if (mem_en === 1'b1) begin
      if (mem_rw) ram[mem_addr] <= mem_wdata;
      else        ram_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = ram_q;

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] ref_mem [256];
  bit            ref_init = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic          exp_own_q[$];
  int            exp_due_q[$];
  bit            m_forced;
  int            m_wait, m_burst;
  logic          e_en, e_rw;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;
  bit            live = 1'b0;
  int            cyc = 0;
  int            win;
  logic          x_pv, x_dv;
  logic [DW-1:0] x_d;

  // Per-cycle monitor: registered outputs, read returns, then this cycle's grant.
  always @(negedge clk) begin
    if (!ref_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = DW'((i * 7 + 3) & 8'hFF);
      ref_init = 1'b1;
    end
    if (live) begin
      checks++;
      if ({mem_en, mem_rw, mem_addr, mem_wdata} !== {e_en, e_rw, e_addr, e_wd}) begin
        errors++;
        $display("FAIL mon_mem cyc=%0d got en=%b rw=%b a=%h d=%h exp en=%b rw=%b a=%h d=%h",
                 cyc, mem_en, mem_rw, mem_addr, mem_wdata, e_en, e_rw, e_addr, e_wd);
      end
    end
    x_pv = 1'b0; x_dv = 1'b0; x_d = '0;
    if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
      void'(exp_due_q.pop_front());
      x_d = exp_q.pop_front();
      if (exp_own_q.pop_front()) x_dv = 1'b1; else x_pv = 1'b1;
    end
    if (live) begin
      checks++;
      if ({pipe_rvalid, dma_rvalid} !== {x_pv, x_dv}) begin
        errors++;
        $display("FAIL mon_rvalid cyc=%0d got p=%b d=%b exp p=%b d=%b",
                 cyc, pipe_rvalid, dma_rvalid, x_pv, x_dv);
      end
      if (x_pv || x_dv) begin
        checks++;
        if ((x_pv ? pipe_rdata : dma_rdata) !== x_d) begin
          errors++;
          $display("FAIL mon_rdata cyc=%0d got %h exp %h", cyc,
                   x_pv ? pipe_rdata : dma_rdata, x_d);
        end
      end
    end
    if (reset) begin
      checks++;
      if ({pipe_stall, dma_gnt} !== {pipe_en, 1'b0}) begin
        errors++;
        $display("FAIL mon_reset_gnt cyc=%0d got stall=%b gnt=%b exp stall=%b gnt=0",
                 cyc, pipe_stall, dma_gnt, pipe_en);
      end
      exp_q.delete(); exp_own_q.delete(); exp_due_q.delete();
      m_forced = 1'b0; m_wait = 0; m_burst = 0;
      e_en = 1'b0; e_rw = 1'b0; e_addr = '0; e_wd = '0;
      live = 1'b1;
    end else if (live) begin
      // Who should win this cycle (0 none, 1 pipeline, 2 DMA).
      win = 0;
      if (m_forced) begin
        if (dma_req) win = 2; else if (pipe_en) win = 1;
      end else if (dma_req && m_wait >= STARVE_LIMIT) win = 2;
      else if (pipe_en) win = 1;
      else if (dma_req) win = 2;
      checks++;
      if ({pipe_stall, dma_gnt} !== {pipe_en && win != 1, win == 2}) begin
        errors++;
        $display("FAIL mon_grant cyc=%0d got stall=%b gnt=%b exp stall=%b gnt=%b",
                 cyc, pipe_stall, dma_gnt, pipe_en && win != 1, win == 2);
      end
      if (win == 2) begin
        if (m_forced || m_wait >= STARVE_LIMIT) begin
          if (!m_forced) begin m_forced = 1'b1; m_burst = 0; end
          m_burst++;
          if (m_burst >= MAX_BURST) begin m_forced = 1'b0; m_burst = 0; end
        end
        m_wait = 0;
      end else begin
        if (m_forced) begin m_forced = 1'b0; m_burst = 0; end
        if (dma_req) begin
          if (m_wait < STARVE_LIMIT) m_wait++;
        end else m_wait = 0;
      end
      if (win == 0) begin
        e_en = 1'b0; e_rw = 1'b0;
      end else begin
        e_en   = 1'b1;
        e_rw   = (win == 1) ? pipe_rw : dma_rw;
        e_addr = (win == 1) ? pipe_addr : dma_addr;
        e_wd   = (win == 1) ? pipe_wdata : dma_wdata;
        if (e_rw) ref_mem[e_addr] = e_wd;
        else begin
          exp_q.push_back(ref_mem[e_addr]);
          exp_own_q.push_back(win == 2);
          exp_due_q.push_back(cyc + 2);
        end
      end
    end
    cyc++;
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_en = 1'b0; pipe_rw = 1'b0; pipe_addr = '0; pipe_wdata = '0;
    dma_req = 1'b0; dma_rw = 1'b0; dma_addr = '0; dma_wdata = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick(); tick();
    checks++;
    if ({mem_en, mem_rw, mem_addr, pipe_rvalid, dma_rvalid} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got en=%b rw=%b a=%h prv=%b drv=%b exp all zero",
               mem_en, mem_rw, mem_addr, pipe_rvalid, dma_rvalid);
    end
    reset = 1'b0;
  endtask

  task automatic test_pipe_write();
    pipe_en = 1'b1; pipe_rw = 1'b1; pipe_addr = 8'h05; pipe_wdata = 8'h50;
    @(negedge clk);
    checks++;
    if (pipe_stall !== 1'b0) begin
      errors++; $display("FAIL pw_stall got %b exp 0", pipe_stall);
    end
    tick();
    pipe_en = 1'b0;
    checks++;
    if ({mem_en, mem_rw, mem_addr, mem_wdata, pipe_rvalid, dma_rvalid} !==
        {1'b1, 1'b1, 8'h05, 8'h50, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL pw_cmd got en=%b rw=%b a=%h d=%h prv=%b drv=%b exp 1 1 05 50 0 0",
               mem_en, mem_rw, mem_addr, mem_wdata, pipe_rvalid, dma_rvalid);
    end
  endtask

  task automatic test_pipe_read();
    pipe_en = 1'b1; pipe_rw = 1'b0; pipe_addr = 8'h05;
    @(negedge clk);
    checks++;
    if (pipe_stall !== 1'b0) begin
      errors++; $display("FAIL pr_stall got %b exp 0", pipe_stall);
    end
    tick();
    pipe_en = 1'b0;
    checks++;
    if (pipe_rvalid !== 1'b0) begin
      errors++; $display("FAIL pr_early got pipe_rvalid=%b exp 0", pipe_rvalid);
    end
    tick();
    checks++;
    if ({pipe_rvalid, pipe_rdata, dma_rvalid} !== {1'b1, 8'h50, 1'b0}) begin
      errors++;
      $display("FAIL pr_data got prv=%b d=%h drv=%b exp 1 50 0", pipe_rvalid, pipe_rdata, dma_rvalid);
    end
  endtask

  task automatic test_contention();
    logic exp_dma;
    pipe_en = 1'b1; pipe_rw = 1'b0; pipe_addr = 8'h05;
    dma_req = 1'b1; dma_rw = 1'b1; dma_addr = 8'h40; dma_wdata = 8'hC3;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      exp_dma = ((c >= 9) && (c <= 12)) || ((c >= 21) && (c <= 24));
      checks++;
      if ({dma_gnt, pipe_stall} !== {exp_dma, exp_dma}) begin
        errors++;
        $display("FAIL contention c=%0d got gnt=%b stall=%b exp %b", c, dma_gnt, pipe_stall, exp_dma);
      end
      tick();
    end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_dma_only();
    pipe_en = 1'b0; dma_req = 1'b1; dma_rw = 1'b0; dma_addr = 8'h1F;
    @(negedge clk);
    checks++;
    if (dma_gnt !== 1'b1) begin
      errors++; $display("FAIL dma_gnt got %b exp 1", dma_gnt);
    end
    tick();
    dma_req = 1'b0;
    tick();
    checks++;
    if ({dma_rvalid, dma_rdata, pipe_rvalid} !== {1'b1, ref_mem[8'h1F], 1'b0}) begin
      errors++;
      $display("FAIL dma_read got drv=%b d=%h prv=%b exp 1 %h 0",
               dma_rvalid, dma_rdata, pipe_rvalid, ref_mem[8'h1F]);
    end
  endtask

  task automatic test_reset_mid_op();
    pipe_en = 1'b1; pipe_rw = 1'b0; pipe_addr = 8'h05;
    @(negedge clk);
    checks++;
    if (pipe_stall !== 1'b0) begin
      errors++; $display("FAIL rmo_grant got stall=%b exp 0", pipe_stall);
    end
    tick();
    reset = 1'b1; pipe_en = 1'b0; dma_req = 1'b1; dma_rw = 1'b1; dma_addr = 8'h22;
    tick();
    reset = 1'b0;
    checks++;
    if (dbg_state !== PIPE_PRIO) begin
      errors++; $display("FAIL rmo_state got %0d exp %0d", dbg_state, PIPE_PRIO);
    end
    pipe_en = 1'b1; pipe_rw = 1'b1; pipe_wdata = 8'h11;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      checks++;
      if ({pipe_rvalid, dma_gnt} !== {1'b0, c == 9}) begin
        errors++;
        $display("FAIL rmo_starve c=%0d got prv=%b gnt=%b exp 0 %b", c, pipe_rvalid, dma_gnt, c == 9);
      end
      tick();
    end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset      = ($urandom_range(0, 59) == 0);
      pipe_en    = ($urandom_range(0, 99) < 60);
      pipe_rw    = $urandom_range(0, 1);
      pipe_addr  = AW'($urandom_range(0, 15));
      pipe_wdata = DW'($urandom);
      dma_req    = ($urandom_range(0, 99) < 50);
      dma_rw     = $urandom_range(0, 1);
      dma_addr   = AW'($urandom_range(0, 15));
      dma_wdata  = DW'($urandom);
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    tick(); tick(); tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_pipe_write();
    test_pipe_read();
    test_contention();
    test_dma_only();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Arbitrates the single-port 8-bit data memory of the pipelined processor between two requesters: the pipeline EX→DM path and a secondary DMA/loader port. The pipeline normally has priority. A starvation counter forces bounded DMA bursts and stalls the pipeline while they run. Issues registered memory commands and routes returned read data to its owner.

Parameters:
AW, 8, address width (the pipeline ALU result is used as the address)
DW, 8, data width
STARVE_LIMIT, 8, number of consecutive denied DMA-request cycles before DMA is forced (>=1)
MAX_BURST, 4, maximum consecutive forced DMA grants before the pipeline regains priority (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
pipe_en  in  1  pipeline memory request (held while stalled)
pipe_rw  in  1  1=write, 0=read
pipe_addr  in  AW  pipeline address
pipe_wdata  in  DW  pipeline store data (bypassed B operand)
pipe_stall  out  1  pipeline request not granted this cycle
pipe_rdata  out  DW  read data to pipeline
pipe_rvalid  out  1  pipe_rdata valid strobe
dma_req  in  1  DMA request (held until granted)
dma_rw  in  1  1=write, 0=read
dma_addr  in  AW  DMA address
dma_wdata  in  DW  DMA write data
dma_gnt  out  1  DMA request accepted at this edge
dma_rdata  out  DW  read data to DMA
dma_rvalid  out  1  dma_rdata valid strobe
mem_en  out  1  memory enable (registered)
mem_rw  out  1  memory write strobe (registered)
mem_addr  out  AW  memory address (registered)
mem_wdata  out  DW  memory write data (registered)
mem_rdata  in  DW  synchronous RAM output, valid the cycle after mem_en=1 with mem_rw=0

Behaviour:
- FSM states: PIPE_PRIO (reset state) and DMA_PRIO. Counters: wait_cnt (0..STARVE_LIMIT, saturating) and burst_cnt (0..MAX_BURST).
- PIPE_PRIO:
  - If dma_req=1 and wait_cnt==STARVE_LIMIT: grant DMA, go to DMA_PRIO, burst_cnt<=1.
  - Else if pipe_en=1: grant the pipeline.
  - Else if dma_req=1: grant DMA.
- DMA_PRIO:
  - If dma_req=1: grant DMA, burst_cnt++. Return to PIPE_PRIO when this grant makes burst_cnt==MAX_BURST.
  - If dma_req=0: return to PIPE_PRIO in the same cycle and grant the pipeline if pipe_en=1 (no idle bubble).
- wait_cnt:
  - Increments when dma_req=1 and DMA is not granted (saturates).
  - Clears on any DMA grant or when dma_req=0.
  - burst_cnt clears on exit from DMA_PRIO.
- Grant signals are combinational: pipe_stall = pipe_en & ~pipe_granted; dma_gnt = dma_req & dma_granted. Never both granted in one cycle.
- Command issue: at the edge ending grant cycle T, mem_en/mem_rw/mem_addr/mem_wdata load from the winner. With no grant, mem_en<=0 and mem_rw<=0; addr/wdata hold their previous values.
- Read return:
  - A 2-stage tag pipeline {valid, owner} tracks reads only; writes produce no strobe.
  - Read data is valid in cycle T+2. pipe_rvalid/dma_rvalid = tag stage-2 valid & owner match.
  - pipe_rdata and dma_rdata both pass mem_rdata through combinationally.
  - Latency: grant cycle T → data cycle T+2. Writes are committed by the RAM at the end of T+1.
- Back-to-back grants to either owner are allowed every cycle; throughput is 1 access/cycle.
- Reset (synchronous, any cycle):
  - State returns to PIPE_PRIO; wait_cnt, burst_cnt, mem_en, mem_rw, mem_addr and mem_wdata all go to 0; tag pipeline clears.
  - In-flight reads are dropped: no rvalid after reset.
  - While reset=1, pipe_stall=pipe_en and dma_gnt=0.

Decomposition:
- Shared package dmem_pkg: owner encoding (OWN_PIPE=0, OWN_DMA=1), FSM state encoding, and the RW_READ/RW_WRITE constants.
- One natural sub-module, dmem_rtag_pipe: the 2-stage {valid, owner} read-tag shift register.
- Arbitration FSM and counters stay in the top level.

Test Plan:
- Reset: reset=1 for 2 cycles with pipe_en=0 and dma_req=0 → mem_en=0, mem_rw=0, mem_addr=8'h00, pipe_rvalid=0, dma_rvalid=0.
- Pipeline write: pipe_en=1, pipe_rw=1, pipe_addr=8'h05, pipe_wdata=8'h50 → next cycle mem_en=1, mem_rw=1, mem_addr=8'h05, mem_wdata=8'h50; pipe_stall=0; no rvalid.
- Pipeline read: pipe_rw=0, pipe_addr=8'h05, RAM model holds 8'h50 → pipe_rvalid=1 and pipe_rdata=8'h50 exactly 2 cycles after the grant; dma_rvalid=0.
- Contention: pipe_en and dma_req held at 1 (defaults) → pipeline granted for 8 cycles; DMA granted in cycles 9-12 with pipe_stall=1; pipeline granted in cycle 13; DMA forced again in cycles 21-24.
- DMA only: pipe_en=0, dma_req=1, dma_rw=0, dma_addr=8'h1F → dma_gnt=1 in the same cycle, dma_rvalid=1 two cycles later, pipe_rvalid=0.
- Reset mid-op: grant a pipeline read, then assert reset in the next cycle → no pipe_rvalid in any following cycle; state PIPE_PRIO; a DMA request held from reset release needs 8 denials before being forced.
